// File: rtl/cache_controller.sv
// Direct-mapped, write-through, no-write-allocate L1 cache controller (64 lines x 2 words).
// Optional hit/miss statistics counters are enabled by defining CACHE_STATS_EN.
module cache_controller (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_rd_en,
  input  logic        mem_wr_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic        sram_rd_en,
  output logic        sram_wr_en,
  output logic [31:0] sram_address,
  output logic [31:0] sram_write_data,
  input  logic [31:0] sram_read_data,
  input  logic        sram_ready
`ifdef CACHE_STATS_EN
  ,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
`endif
);

  typedef enum logic [1:0] {IDLE, FILL0, FILL1, WRITE} state_t;

  state_t      state_q;
  logic [63:0] valid_q;
  logic        sram_rd_en_q;
  logic        sram_wr_en_q;
  logic [31:0] sram_addr_q;
  logic [31:0] wr_data_q;
  logic        word_sel_q;

  logic [22:0] tag_mem   [64];
  logic [31:0] word0_mem [64];
  logic [31:0] word1_mem [64];

  logic [5:0]  req_idx;
  logic [5:0]  line_idx;
  logic        lookup_hit;
  logic        line_hit;

  assign req_idx    = address[8:3];
  // sram_addr_q doubles as the fill/write address; +4 in FILL1 never changes index or tag
  assign line_idx   = sram_addr_q[8:3];
  assign lookup_hit = valid_q[req_idx] && (tag_mem[req_idx] == address[31:9]);
  assign line_hit   = valid_q[line_idx] && (tag_mem[line_idx] == sram_addr_q[31:9]);

  assign sram_rd_en      = sram_rd_en_q;
  assign sram_wr_en      = sram_wr_en_q;
  assign sram_address    = sram_addr_q;
  assign sram_write_data = wr_data_q;

`ifdef CACHE_STATS_EN
  logic [15:0] hit_count_q;
  logic [15:0] miss_count_q;
  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      valid_q      <= '0;
      sram_rd_en_q <= 1'b0;
      sram_wr_en_q <= 1'b0;
      sram_addr_q  <= '0;
      wr_data_q    <= '0;
      word_sel_q   <= 1'b0;
`ifdef CACHE_STATS_EN
      hit_count_q  <= '0;
      miss_count_q <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (mem_wr_en) begin
            state_q      <= WRITE;
            sram_wr_en_q <= 1'b1;
            sram_addr_q  <= address;
            wr_data_q    <= write_data;
          end else if (mem_rd_en) begin
`ifdef CACHE_STATS_EN
            if (lookup_hit) begin
              if (hit_count_q != 16'hFFFF) hit_count_q <= hit_count_q + 16'd1;
            end else begin
              if (miss_count_q != 16'hFFFF) miss_count_q <= miss_count_q + 16'd1;
            end
`endif
            if (!lookup_hit) begin
              state_q      <= FILL0;
              sram_rd_en_q <= 1'b1;
              sram_addr_q  <= {address[31:3], 3'b000};
              word_sel_q   <= address[2];
            end
          end
        end
        FILL0: begin
          if (sram_ready) begin
            state_q     <= FILL1;
            sram_addr_q <= sram_addr_q + 32'd4;
          end
        end
        FILL1: begin
          if (sram_ready) begin
            state_q           <= IDLE;
            sram_rd_en_q      <= 1'b0;
            sram_addr_q       <= '0;
            valid_q[line_idx] <= 1'b1;
          end
        end
        WRITE: begin
          if (sram_ready) begin
            state_q      <= IDLE;
            sram_wr_en_q <= 1'b0;
            sram_addr_q  <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Tag/data arrays carry no reset; validity alone decides whether contents are trusted
  always_ff @(posedge clk) begin
    case (state_q)
      FILL0: if (sram_ready) word0_mem[line_idx] <= sram_read_data;
      FILL1: begin
        if (sram_ready) begin
          word1_mem[line_idx] <= sram_read_data;
          tag_mem[line_idx]   <= sram_addr_q[31:9];
        end
      end
      WRITE: begin
        if (sram_ready && line_hit) begin
          if (sram_addr_q[2]) word1_mem[line_idx] <= wr_data_q;
          else                word0_mem[line_idx] <= wr_data_q;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    ready     = 1'b1;
    read_data = address[2] ? word1_mem[req_idx] : word0_mem[req_idx];
    case (state_q)
      IDLE: begin
        if (mem_wr_en)                    ready = 1'b0;
        else if (mem_rd_en && !lookup_hit) ready = 1'b0;
      end
      FILL0: ready = 1'b0;
      FILL1: begin
        // A dropped request still finishes the fill but gets no ready pulse
        ready     = sram_ready && mem_rd_en && !mem_wr_en;
        read_data = word_sel_q ? sram_read_data : word0_mem[line_idx];
      end
      WRITE: ready = sram_ready && mem_wr_en;
      default: ready = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_cache_controller.sv
// Self-checking bench for cache_controller: SRAM responder model, shadow tag model and read-data scoreboard.
module tb_cache_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_rd_en = 1'b0;
  logic        mem_wr_en = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] write_data = '0;
  logic [31:0] read_data;
  logic        ready;
  logic        sram_rd_en;
  logic        sram_wr_en;
  logic [31:0] sram_address;
  logic [31:0] sram_write_data;
  logic [31:0] sram_read_data = '0;
  logic        sram_ready = 1'b0;
`ifdef CACHE_STATS_EN
  logic [15:0] hit_count;
  logic [15:0] miss_count;
`endif

  cache_controller dut (
    .clk(clk), .rst(rst), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
    .address(address), .write_data(write_data), .read_data(read_data), .ready(ready),
    .sram_rd_en(sram_rd_en), .sram_wr_en(sram_wr_en), .sram_address(sram_address),
    .sram_write_data(sram_write_data), .sram_read_data(sram_read_data), .sram_ready(sram_ready)
`ifdef CACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } xfer_t;

  int          checks = 0;
  int          errors = 0;
  int          lat = 2;
  int          cnt = 0;
  logic [31:0] sram_mem [logic [31:0]];
  logic [31:0] ref_mem  [logic [31:0]];
  xfer_t       log_q [$];
  logic [31:0] exp_q [$];
  bit          sh_valid [64];
  logic [22:0] sh_tag   [64];

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return a ^ 32'hC0DE_0000 ^ {a[15:0], 16'h0};
  endfunction

  function automatic logic [31:0] sram_rd(input logic [31:0] a);
    return sram_mem.exists(a) ? sram_mem[a] : dflt(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  // SRAM responder: completes each command after `lat` idle cycles with a one-cycle sram_ready
  always @(negedge clk or negedge rst) begin
    if (!rst) begin
      sram_ready = 1'b0;
      cnt = 0;
    end else if (sram_ready) begin
      sram_ready = 1'b0;
    end else if (sram_rd_en || sram_wr_en) begin
      if (cnt >= lat) begin
        cnt = 0;
        sram_ready = 1'b1;
        if (sram_wr_en) begin
          sram_mem[sram_address] = sram_write_data;
          log_q.push_back({1'b1, sram_address, sram_write_data});
        end else begin
          sram_read_data = sram_rd(sram_address);
          log_q.push_back({1'b0, sram_address, sram_read_data});
        end
      end else begin
        cnt++;
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      checks++;
      if (sram_rd_en && sram_wr_en) begin
        errors++;
        $display("FAIL sram_excl: rd_en=%b wr_en=%b, required not both 1", sram_rd_en, sram_wr_en);
      end
    end
  end

  task automatic apply_reset();
    mem_rd_en = 1'b0;
    mem_wr_en = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (sram_rd_en !== 1'b0 || sram_wr_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_sram_cmd: rd_en=%b wr_en=%b, required 0 0", sram_rd_en, sram_wr_en);
    end
    rst = 1'b1;
    for (int i = 0; i < 64; i++) sh_valid[i] = 1'b0;
  endtask

  task automatic do_load(input logic [31:0] a);
    bit          exp_hit;
    bit          done;
    int          idx, n0, cyc;
    logic [31:0] got, exp, base;
    logic        got_sr, got_rd;
    idx     = int'(a[8:3]);
    exp_hit = sh_valid[idx] && (sh_tag[idx] == a[31:9]);
    base    = {a[31:3], 3'b000};
    exp_q.push_back(ref_rd(a));
    n0 = log_q.size();
    @(negedge clk);
    mem_rd_en = 1'b1; mem_wr_en = 1'b0; address = a;
    cyc = 0; done = 0; got = '0; got_sr = 0; got_rd = 0;
    while (!done && cyc < 200) begin
      #3;
      if (ready) begin
        done = 1; got = read_data; got_sr = sram_ready; got_rd = sram_rd_en;
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    exp = exp_q.pop_front();
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL load_timeout: addr=%h no ready within 200 cycles", a);
    end else begin
      if (got !== exp) begin
        errors++;
        $display("FAIL load_data: addr=%h got %h, required %h", a, got, exp);
      end
      checks++;
      if ((cyc == 0) != exp_hit) begin
        errors++;
        $display("FAIL load_hit: addr=%h latency %0d, required hit=%0d", a, cyc, exp_hit);
      end
      checks++;
      if (exp_hit) begin
        if (log_q.size() != n0 || got_rd !== 1'b0) begin
          errors++;
          $display("FAIL hit_traffic: addr=%h sram xfers %0d rd_en=%b, required 0 0", a, log_q.size() - n0, got_rd);
        end
      end else begin
        if (log_q.size() != n0 + 2 || got_sr !== 1'b1) begin
          errors++;
          $display("FAIL miss_traffic: addr=%h xfers %0d sram_ready=%b, required 2 1", a, log_q.size() - n0, got_sr);
        end else if (log_q[n0].wr || log_q[n0+1].wr || log_q[n0].addr != base || log_q[n0+1].addr != base + 32'd4) begin
          errors++;
          $display("FAIL miss_addrs: addr=%h got %h %h, required reads %h %h", a, log_q[n0].addr, log_q[n0+1].addr, base, base + 32'd4);
        end
      end
    end
    @(negedge clk);
    mem_rd_en = 1'b0;
    if (!exp_hit) begin
      sh_valid[idx] = 1'b1;
      sh_tag[idx]   = a[31:9];
    end
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d);
    bit   done;
    int   n0, cyc;
    logic got_sr;
    n0 = log_q.size();
    @(negedge clk);
    mem_wr_en = 1'b1; mem_rd_en = 1'b0; address = a; write_data = d;
    cyc = 0; done = 0; got_sr = 0;
    while (!done && cyc < 200) begin
      #3;
      if (ready) begin
        done = 1; got_sr = sram_ready;
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL store_timeout: addr=%h no ready within 200 cycles", a);
    end else if (got_sr !== 1'b1 || log_q.size() != n0 + 1) begin
      errors++;
      $display("FAIL store_traffic: addr=%h xfers %0d sram_ready=%b, required 1 1", a, log_q.size() - n0, got_sr);
    end else if (!log_q[n0].wr || log_q[n0].addr != a || log_q[n0].data != d) begin
      errors++;
      $display("FAIL store_xfer: got wr=%b %h %h, required wr=1 %h %h", log_q[n0].wr, log_q[n0].addr, log_q[n0].data, a, d);
    end
    ref_mem[a] = d;
    @(negedge clk);
    mem_wr_en = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    #3;
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b, required 1", ready);
    end
  endtask

  task automatic test_fill();
    do_load(32'h0000_0404);
  endtask

  task automatic test_read_hit();
    do_load(32'h0000_0400);
  endtask

  task automatic test_store_hit();
    do_store(32'h0000_0400, 32'hDEAD_BEEF);
    do_load(32'h0000_0400);
  endtask

  task automatic test_conflict();
    do_load(32'h0000_0600);
    do_load(32'h0000_0400);
  endtask

  task automatic test_store_miss();
    do_store(32'h0000_0800, 32'h5A5A_1234);
    do_load(32'h0000_0800);
  endtask

  task automatic test_drop();
    int n0, cyc;
    logic got_rdy;
    n0 = log_q.size();
    @(negedge clk);
    mem_rd_en = 1'b1; address = 32'h0000_1004;
    cyc = 0;
    while (log_q.size() < n0 + 1 && cyc < 200) begin @(negedge clk); #1; cyc++; end
    mem_rd_en = 1'b0;
    got_rdy = 1'b1;
    while (log_q.size() < n0 + 2 && cyc < 400) begin @(negedge clk); #1; cyc++; end
    #2;
    got_rdy = ready;
    checks++;
    if (log_q.size() != n0 + 2 || got_rdy !== 1'b0) begin
      errors++;
      $display("FAIL drop_ready: xfers %0d ready=%b, required 2 0", log_q.size() - n0, got_rdy);
    end
    sh_valid[int'(address[8:3])] = 1'b1;
    sh_tag[int'(address[8:3])]   = address[31:9];
    do_load(32'h0000_1004);
    do_load(32'h0000_1000);
  endtask

  task automatic test_back_to_back();
    logic [31:0] pool [6];
    pool[0] = 32'h0000_0400; pool[1] = 32'h0000_0604; pool[2] = 32'h0000_1238;
    pool[3] = 32'h0000_023C; pool[4] = 32'h0000_0438; pool[5] = 32'hFFFF_FE3C;
    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(0, 3) == 0)
        do_store(pool[$urandom_range(0, 5)], $urandom);
      else
        do_load(pool[$urandom_range(0, 5)]);
    end
  endtask

  task automatic test_reset_mid_fill();
    int n0, cyc;
    apply_reset();
    n0 = log_q.size();
    @(negedge clk);
    mem_rd_en = 1'b1; address = 32'h0000_0400;
    cyc = 0;
    while (log_q.size() < n0 + 1 && cyc < 200) begin @(negedge clk); #1; cyc++; end
    @(negedge clk);
    #2;
    rst = 1'b0;
    mem_rd_en = 1'b0;
    #1;
    checks++;
    if (sram_rd_en !== 1'b0) begin
      errors++;
      $display("FAIL midfill_rd_en: got %b, required 0", sram_rd_en);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 64; i++) sh_valid[i] = 1'b0;
    do_load(32'h0000_0400);
`ifdef CACHE_STATS_EN
    checks++;
    if (hit_count !== 16'd0 || miss_count !== 16'd1) begin
      errors++;
      $display("FAIL stats: hit=%0d miss=%0d, required 0 1", hit_count, miss_count);
    end
`endif
  endtask

  initial begin
    sram_mem[32'h0000_0400] = 32'h1111_1111;
    sram_mem[32'h0000_0404] = 32'h2222_2222;
    ref_mem[32'h0000_0400]  = 32'h1111_1111;
    ref_mem[32'h0000_0404]  = 32'h2222_2222;
    test_reset();
    test_fill();
    test_read_hit();
    test_store_hit();
    test_conflict();
    test_store_miss();
    test_drop();
    test_back_to_back();
    test_reset_mid_fill();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/cache_controller.md
CACHE_CONTROLLER -- requirements
Module: cache_controller

Interface
REQ-001 clk  input  1  system clock; all state changes on rising edge.
REQ-002 rst  input  1  asynchronous, active-low reset.
REQ-003 mem_rd_en  input  1  load request from MEM stage.
REQ-004 mem_wr_en  input  1  store request from MEM stage.
REQ-005 address  input  32  byte address, word-aligned; [31:9] tag, [8:3] index, [2] word select.
REQ-006 write_data  input  32  store data.
REQ-007 read_data  output  32  load data; valid when ready=1 and mem_rd_en=1.
REQ-008 ready  output  1  1 = current request completes this cycle or no request; 0 = pipeline must freeze.
REQ-009 sram_rd_en / sram_wr_en  output  1 each  read/write command to the SRAM controller.
REQ-010 sram_address  output  32  word address sent to the SRAM controller.
REQ-011 sram_write_data  output  32  store data forwarded to the SRAM controller.
REQ-012 sram_read_data  input  32  data returned by the SRAM controller.
REQ-013 sram_ready  input  1  high for exactly the cycle the SRAM transfer completes.

Function
REQ-014 Storage: direct-mapped, 64 lines; each line has a valid bit, a 23-bit tag and two 32-bit words (64-bit line).
REQ-015 Hit: valid[index]=1 and tag[index]=address[31:9].
REQ-016 FSM states: IDLE, FILL0, FILL1, WRITE.
REQ-017 IDLE read hit: read_data = line word address[2], ready=1 in the same cycle (zero-latency); no SRAM command.
REQ-018 IDLE read miss: ready=0; register {address[31:3],3'b000} into the fill address; go to FILL0.
REQ-019 FILL0: sram_rd_en=1, sram_address=fill address; on sram_ready store sram_read_data as word 0; go to FILL1.
REQ-020 FILL1: sram_rd_en=1, sram_address=fill address+4; on sram_ready store word 1, set tag and valid; go to IDLE.
REQ-021 FILL1 completion cycle: ready=1; read_data bypasses the requested word (word 0 from the line, word 1 from sram_read_data).
REQ-022 Store policy: write-through, no write-allocate; IDLE with mem_wr_en=1 sets ready=0, registers address and data, and moves to WRITE.
REQ-023 WRITE: sram_wr_en=1 with the registered address and data; on sram_ready set ready=1 and return to IDLE.
REQ-024 WRITE completion on a hit: update the cached word in the same cycle; a store miss leaves the array untouched.
REQ-025 mem_rd_en and mem_wr_en both high: treat as a store.
REQ-026 sram_rd_en and sram_wr_en are never both high; both are 0 in IDLE.
REQ-027 Inputs must be held stable until ready=1.
REQ-028 Request dropped mid-transfer: the FSM still completes the SRAM transfer (fill still installs the line), does not assert ready for it, then returns to IDLE.
REQ-029 No request in IDLE: ready=1; read_data is don't-care.

Reset
REQ-030 rst=0 asynchronously clears all 64 valid bits, forces IDLE, and drives sram_rd_en=0 and sram_wr_en=0.
REQ-031 Tag and data arrays are not reset; the fill address and write registers reset to 0.
REQ-032 Reset asserted mid-fill: abandon the fill and leave the line invalid.
REQ-033 After reset release, the first read of any address is a miss.

Configuration
REQ-034 Macro CACHE_STATS_EN defined: add output ports hit_count[15:0] and miss_count[15:0], both reset to 0.
REQ-035 With CACHE_STATS_EN: count each load once at IDLE lookup; counters saturate at 16'hFFFF; stores are not counted.
REQ-036 Macro CACHE_STATS_EN undefined: the ports and counters do not exist; all other behaviour is identical.

Verification
REQ-037 Reset, then load 0x0000_0404 with SRAM returning 0x1111_1111 then 0x2222_2222 -> two SRAM reads at 0x400 and 0x404; ready=1 in the FILL1 completion cycle; read_data=0x2222_2222.
REQ-038 Then load 0x0000_0400 -> ready=1 in the same cycle, read_data=0x1111_1111, no sram_rd_en.
REQ-039 Store 0xDEAD_BEEF to 0x400 (hit) -> one sram_wr_en; then load 0x400 is a hit returning 0xDEAD_BEEF.
REQ-040 Load 0x0000_0600 (same index, different tag) after 0x400 is resident -> miss and refill; a following load of 0x400 misses again.
REQ-041 Store to uncached 0x800 -> SRAM write only; a following load of 0x800 misses.
REQ-042 rst=0 during FILL1, then load 0x400 -> miss; with CACHE_STATS_EN, hit_count=0 and miss_count=1 after reset and that load.
